i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_tick_gen.sv | 43 ++++
 rtl/i2c_master.sv | 181 ++++++++++++++++++
 tb/tb_i2c_master.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master slice.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        STOP
    } state_t;

    typedef logic [1:0] quarter_t;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned QUARTERS      = 4;

    localparam quarter_t   Q_SAMPLE = 2'd2;
    localparam quarter_t   Q_LAST   = quarter_t'(QUARTERS - 1);
    localparam logic [2:0] BIT_LAST = 3'(BITS_PER_BYTE - 1);

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period strobe generator: tick_o marks the last clk of each SCL
// quarter, quarter_o is the index Q0..Q3 of the quarter in progress.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       tick_o,
    output logic [1:0] quarter_o
);

    localparam logic [9:0] CNT_LAST = 10'(CLK_DIV - 1);

    logic [9:0] cnt_q, cnt_d;
    quarter_t   quarter_q, quarter_d;

    // Count clk cycles within a quarter and advance the quarter index on wrap.
    always_comb begin
        cnt_d     = cnt_q + 10'd1;
        quarter_d = quarter_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            quarter_d = (quarter_q == Q_LAST) ? '0 : quarter_q + 2'd1;
        end
    end

    // Counter registers, cleared whenever the master is idle or in reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            quarter_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end

    assign tick_o    = (cnt_q == CNT_LAST);
    assign quarter_o = quarter_q;

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master (write or read one byte to a 7-bit address).
// Optional macro I2C_MASTER_SDA_SYNC_EN adds a two-flop SDA input synchronizer.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl,
    inout  logic       sda
);

    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] addr_rw_q, addr_rw_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_error_q, ack_error_d;
    logic       done_q, done_d;

    logic       tick;
    quarter_t   quarter;
    logic       bit_end;
    logic       sample;
    logic       sda_in;
    logic       sda_low;
    logic [2:0] bit_idx;

    assign busy = (state_q != IDLE);

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i     (clk),
        .rst_i     (rst | ~busy),
        .tick_o    (tick),
        .quarter_o (quarter)
    );

    assign bit_end = tick && (quarter == Q_LAST);
    assign sample  = tick && (quarter == Q_SAMPLE);
    assign bit_idx = BIT_LAST - bitcnt_q;

`ifdef I2C_MASTER_SDA_SYNC_EN
    logic [1:0] sda_sync_q;

    // Two-flop synchronizer on the SDA input; settles well inside Q2.
    always_ff @(posedge clk) begin
        if (rst) sda_sync_q <= '1;
        else     sda_sync_q <= {sda_sync_q[0], sda};
    end

    assign sda_in = sda_sync_q[1];
`else
    assign sda_in = sda;
`endif

    // Next-state logic: phase sequencing, bit counting, ACK and read capture.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        addr_rw_d   = addr_rw_q;
        wdata_d     = wdata_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        ack_error_d = ack_error_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = START;
                    addr_rw_d   = {addr, rw};
                    wdata_d     = wdata;
                    ack_error_d = 1'b0;
                    bitcnt_d    = '0;
                end
            end
            START: if (bit_end) state_d = ADDR;
            ADDR, WRITE, READ: begin
                if (state_q == READ && sample) rx_d = {rx_q[6:0], sda_in};
                if (bit_end) begin
                    bitcnt_d = (bitcnt_q == BIT_LAST) ? '0 : bitcnt_q + 3'd1;
                    if (bitcnt_q == BIT_LAST) begin
                        case (state_q)
                            ADDR:    state_d = ADDR_ACK;
                            WRITE:   state_d = WRITE_ACK;
                            default: state_d = READ_ACK;
                        endcase
                    end
                end
            end
            ADDR_ACK: begin
                if (sample && sda_in) ack_error_d = 1'b1;
                if (bit_end) begin
                    if (ack_error_q)       state_d = STOP;
                    else if (addr_rw_q[0]) state_d = READ;
                    else                   state_d = WRITE;
                end
            end
            WRITE_ACK: begin
                if (sample && sda_in) ack_error_d = 1'b1;
                if (bit_end) state_d = STOP;
            end
            READ_ACK: begin
                if (bit_end) begin
                    state_d = STOP;
                    rdata_d = rx_q;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus drive: SCL low in Q0-Q1 of every bit except START; SDA only changes at Q0 outside START/STOP.
    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state_q)
            START: sda_low = quarter[1];
            ADDR: begin
                scl     = quarter[1];
                sda_low = ~addr_rw_q[bit_idx];
            end
            WRITE: begin
                scl     = quarter[1];
                sda_low = ~wdata_q[bit_idx];
            end
            ADDR_ACK, WRITE_ACK, READ, READ_ACK: scl = quarter[1];
            STOP: begin
                scl     = quarter[1];
                sda_low = (quarter != Q_LAST);
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset releases the bus immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            addr_rw_q   <= '0;
            wdata_q     <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            ack_error_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            addr_rw_q   <= addr_rw_d;
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            ack_error_q <= ack_error_d;
            done_q      <= done_d;
        end
    end

    assign sda       = sda_low ? 1'b0 : 1'bz;
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign ack_error = ack_error_q;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master with a bus-level slave model at 0x50.
module tb_i2c_master;

    localparam int unsigned K          = 4;
    localparam logic [6:0]  SLAVE_ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_error;
    logic       scl;
    wire        sda_w;

    logic       sl_low = 1'b0;

    pullup (sda_w);
    assign sda_w = sl_low ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .scl       (scl),
        .sda       (sda_w)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model and bus-condition monitor, evaluated on the falling clk edge.
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    bit         sl_active = 0;
    bit         sl_match  = 0;
    bit         sl_rw     = 0;
    int         sl_edges  = 0;
    int         sl_next;
    logic [7:0] sl_addr_byte = '0;
    logic [7:0] sl_shift = '0;
    logic [7:0] sl_tx = '0;
    logic [7:0] sl_rx = '0;
    int         sl_valid_cnt   = 0;
    int         sl_frame_edges = 0;
    int         sl_master_ack  = -1;
    int         start_conds = 0;
    int         stop_conds  = 0;
    int         done_cnt    = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (p_scl && scl && (sda_w !== p_sda)) begin
            // Any SDA movement while SCL stays high is a START (fall) or STOP (rise).
            if (!sda_w) begin
                start_conds++;
                sl_active = 1;
                sl_edges  = 0;
                sl_match  = 0;
            end else begin
                stop_conds++;
                sl_frame_edges = sl_edges;
                sl_active = 0;
            end
            sl_low <= 1'b0;
        end else if (sl_active && !p_scl && scl) begin
            sl_edges++;
            if (sl_edges <= 8) begin
                sl_addr_byte[8 - sl_edges] = sda_w;
                if (sl_edges == 8) begin
                    sl_match = (sl_addr_byte[7:1] == SLAVE_ADDR);
                    sl_rw    = sl_addr_byte[0];
                end
            end else if (sl_match && sl_edges >= 10 && sl_edges <= 17) begin
                sl_shift[17 - sl_edges] = sda_w;
                if (sl_edges == 17 && !sl_rw) begin
                    sl_rx = sl_shift;
                    sl_valid_cnt++;
                end
            end else if (sl_match && sl_rw && sl_edges == 18) begin
                sl_master_ack = int'(sda_w);
            end
        end else if (sl_active && p_scl && !scl) begin
            sl_next = sl_edges + 1;
            if (sl_next == 9)
                sl_low <= sl_match;
            else if (sl_match && sl_rw && sl_next >= 10 && sl_next <= 17)
                sl_low <= ~sl_tx[17 - sl_next];
            else if (sl_match && !sl_rw && sl_next == 18)
                sl_low <= 1'b1;
            else
                sl_low <= 1'b0;
        end
        p_scl = scl;
        p_sda = sda_w;
    end

    // Reference model state.
    logic [7:0] model_rdata = '0;
    int         base_starts;
    int         base_stops;
    int         exp_starts = 0;
    int         exp_stops  = 0;

    task automatic run_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wdata,
                           input logic [7:0] t_tx, input bit overlap);
        int k;
        bit matched;
        int valid_before;
        int dones_before;
        matched      = (t_addr == SLAVE_ADDR);
        valid_before = sl_valid_cnt;
        dones_before = done_cnt;
        sl_tx         = t_tx;
        sl_master_ack = -1;
        @(negedge clk);
        rw = t_rw; addr = t_addr; wdata = t_wdata; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; rw = ~t_rw; addr = ~t_addr; wdata = ~t_wdata;
        exp_starts++;
        check("busy_after_accept", busy, 1);
        check("ack_cleared", ack_error, 0);
        check("start_q0_scl", scl, 1);
        check("start_q0_sda", sda_w, 1);
        k = 0;
        while (!done && k < 4000) begin
            @(negedge clk);
            k++;
            start = (overlap && k == 100);
        end
        start = 1'b0;
        exp_stops++;
        if (t_rw && matched) model_rdata = t_tx;
        check("done_seen", done, 1);
        check("latency", k, matched ? 80 * K : 44 * K);
        check("busy_at_done", busy, 0);
        check("ack_error", ack_error, {31'd0, !matched});
        check("rdata", rdata, model_rdata);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ack_error_held", ack_error, {31'd0, !matched});
        check("done_count", done_cnt - dones_before, 1);
        check("frame_scl_edges", sl_frame_edges, matched ? 19 : 10);
        check("start_conditions", start_conds - base_starts, exp_starts);
        check("stop_conditions", stop_conds - base_stops, exp_stops);
        if (matched && !t_rw) begin
            check("slave_rx", sl_rx, t_wdata);
            check("slave_valid", sl_valid_cnt - valid_before, 1);
        end else begin
            check("no_write_data", sl_valid_cnt - valid_before, 0);
        end
        if (matched && t_rw) check("master_nack", sl_master_ack, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r_rw;
        logic [6:0] r_addr;
        rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);

        // Reset state, and start presented together with reset is ignored.
        @(negedge clk);
        start = 1'b1; addr = SLAVE_ADDR;
        @(negedge clk);
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_error", ack_error, 0);
        check("rst_rdata", rdata, 0);
        check("rst_scl", scl, 1);
        check("rst_sda", sda_w, 1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_start_ignored", busy, 0);
        base_starts = start_conds;
        base_stops  = stop_conds;

        run_txn(1'b0, SLAVE_ADDR, 8'hA5, 8'h00, 0);
        run_txn(1'b1, SLAVE_ADDR, 8'h00, 8'h3C, 0);
        run_txn(1'b0, 7'h51,      8'h77, 8'h00, 0);
        run_txn(1'b0, SLAVE_ADDR, 8'h5A, 8'h00, 1);

        // Reset during the 4th address bit while SCL is low.
        @(negedge clk);
        rw = 1'b0; addr = SLAVE_ADDR; wdata = 8'hC3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        exp_starts++;
        repeat (16 * K + 1) @(negedge clk);
        check("abort_scl_low", scl, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = '0;
        check("abort_scl", scl, 1);
        check("abort_sda", sda_w, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (4 * K) @(negedge clk);
        check("abort_no_stop", stop_conds - base_stops, exp_stops);

        run_txn(1'b0, SLAVE_ADDR, 8'h96, 8'h00, 0);

        for (int i = 0; i < 8; i++) begin
            r_rw   = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR;
            run_txn(r_rw, r_addr, 8'($urandom), 8'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
